// File: rtl/adv_ctrl_pkg.sv
// Shared types for the adventure controller: FSM states, game result codes, move direction.
// Pure declarations, no latency; no flow control involved.
package adv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESTART = 3'd0,
        ST_IDLE    = 3'd1,
        ST_MOVE    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_DONE    = 3'd4
    } adv_ctrl_state_type;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_WIN     = 2'd1,
        RES_DIE     = 2'd2,
        RES_TIMEOUT = 2'd3
    } adv_result_type;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_S = 2'd1,
        DIR_W = 2'd2,
        DIR_E = 2'd3
    } adv_dir_type;

    localparam int RESTART_CYCLES = 2;

    // press vector is {north, south, west, east}; north wins ties
    function automatic adv_dir_type pick_dir(input logic [3:0] press);
        if (press[3])      return DIR_N;
        else if (press[2]) return DIR_S;
        else if (press[1]) return DIR_W;
        else               return DIR_E;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one synchronised button level; press is combinational off the
// current level, history updates every cycle; no backpressure, presses are never held.
module btn_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) prev_q <= 1'b0;
        else         prev_q <= btn_i;
    end

    assign press_o = btn_i & ~prev_q;

endmodule

// File: rtl/adventure_controller.sv
// Turns button presses into one-cycle move pulses for the room/sword game and tracks game end.
// Move pulse one cycle after the press edge; presses outside IDLE/DONE are dropped, never queued.
module adventure_controller
    import adv_ctrl_pkg::*;
#(
    parameter int MOVE_GAP  = 2,
    parameter int MAX_MOVES = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_north,
    input  logic       btn_south,
    input  logic       btn_west,
    input  logic       btn_east,
    input  logic       win,
    input  logic       die,
    output logic       north,
    output logic       south,
    output logic       west,
    output logic       east,
    output logic       game_reset,
    output logic [7:0] move_count,
    output logic       game_over,
    output logic [1:0] result
);

    logic [3:0]         press;
    adv_ctrl_state_type state_q, state_d;
    adv_dir_type        dir_q, dir_d;
    adv_result_type     result_q, result_d;
    adv_result_type     end_res;
    logic [7:0]         count_q, count_d;
    logic [3:0]         settle_q, settle_d;
    logic               rst_cnt_q, rst_cnt_d;

    btn_edge u_edge_n (.clk_i(clk), .rst_ni(reset), .btn_i(btn_north), .press_o(press[3]));
    btn_edge u_edge_s (.clk_i(clk), .rst_ni(reset), .btn_i(btn_south), .press_o(press[2]));
    btn_edge u_edge_w (.clk_i(clk), .rst_ni(reset), .btn_i(btn_west),  .press_o(press[1]));
    btn_edge u_edge_e (.clk_i(clk), .rst_ni(reset), .btn_i(btn_east),  .press_o(press[0]));

    // End-of-game decision shared by IDLE and the last SETTLE cycle; win beats die beats timeout
    always_comb begin
        end_res = RES_NONE;
        if (win)                          end_res = RES_WIN;
        else if (die)                     end_res = RES_DIE;
        else if (count_q == 8'(MAX_MOVES)) end_res = RES_TIMEOUT;
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        result_d  = result_q;
        count_d   = count_q;
        settle_d  = settle_q;
        rst_cnt_d = rst_cnt_q;
        case (state_q)
            ST_RESTART: begin
                count_d  = 8'd0;
                result_d = RES_NONE;
                if (rst_cnt_q == 1'(RESTART_CYCLES - 1)) begin
                    rst_cnt_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (end_res != RES_NONE) begin
                    result_d = end_res;
                    state_d  = ST_DONE;
                end else if (|press) begin
                    dir_d   = pick_dir(press);
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                settle_d = 4'(MOVE_GAP - 1);
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q != 4'd0) begin
                    settle_d = settle_q - 4'd1;
                end else if (end_res != RES_NONE) begin
                    result_d = end_res;
                    state_d  = ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (|press) begin
                    count_d   = 8'd0;
                    result_d  = RES_NONE;
                    rst_cnt_d = 1'b0;
                    state_d   = ST_RESTART;
                end
            end
            default: begin
                rst_cnt_d = 1'b0;
                state_d   = ST_RESTART;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RESTART;
            dir_q     <= DIR_N;
            result_q  <= RES_NONE;
            count_q   <= 8'd0;
            settle_q  <= 4'd0;
            rst_cnt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            result_q  <= result_d;
            count_q   <= count_d;
            settle_q  <= settle_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    // Outputs decode straight from state so an async reset drops them in the same cycle
    assign north      = (state_q == ST_MOVE) && (dir_q == DIR_N);
    assign south      = (state_q == ST_MOVE) && (dir_q == DIR_S);
    assign west       = (state_q == ST_MOVE) && (dir_q == DIR_W);
    assign east       = (state_q == ST_MOVE) && (dir_q == DIR_E);
    assign game_reset = (state_q == ST_RESTART);
    assign game_over  = (state_q == ST_DONE);
    assign move_count = count_q;
    assign result     = result_q;

endmodule

// File: tb/tb_adventure_controller.sv
// Directed bench for adventure_controller with MOVE_GAP=2, MAX_MOVES=3.
module tb_adventure_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_north, btn_south, btn_west, btn_east;
    logic       win, die;
    logic       north, south, west, east;
    logic       game_reset;
    logic [7:0] move_count;
    logic       game_over;
    logic [1:0] result;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adventure_controller #(.MOVE_GAP(2), .MAX_MOVES(3)) dut (
        .clk(clk), .reset(reset),
        .btn_north(btn_north), .btn_south(btn_south),
        .btn_west(btn_west), .btn_east(btn_east),
        .win(win), .die(die),
        .north(north), .south(south), .west(west), .east(east),
        .game_reset(game_reset), .move_count(move_count),
        .game_over(game_over), .result(result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dirs();
        return {4'b0, north, south, west, east};
    endfunction

    initial begin
        reset = 1'b0;
        {btn_north, btn_south, btn_west, btn_east} = 4'b0;
        win = 1'b0;
        die = 1'b0;
        #1;
        chk("rst_game_reset", {7'b0, game_reset}, 8'd1);
        chk("rst_dirs", dirs(), 8'd0);
        chk("rst_count", move_count, 8'd0);
        chk("rst_result", {6'b0, result}, 8'd0);
        chk("rst_over", {7'b0, game_over}, 8'd0);
        tick(); tick();
        reset = 1'b1;

        // two RESTART cycles, then IDLE
        tick();
        chk("restart_c1", {7'b0, game_reset}, 8'd1);
        tick();
        chk("restart_done", {7'b0, game_reset}, 8'd0);
        chk("idle_count", move_count, 8'd0);
        chk("idle_result", {6'b0, result}, 8'd0);

        // east press: single pulse, count 1
        btn_east = 1'b1;
        tick();
        chk("east_pulse", dirs(), 8'b0001);
        chk("east_count", move_count, 8'd1);
        btn_east = 1'b0;
        tick();
        chk("east_one_cycle", dirs(), 8'd0);
        tick();
        btn_north = 1'b1;          // rises on the last SETTLE edge: ignored
        tick();
        chk("settle_press_ign", dirs(), 8'd0);
        tick();
        chk("held_no_repeat", dirs(), 8'd0);
        chk("held_count", move_count, 8'd1);
        btn_north = 1'b0;
        tick();

        // north and west together: north wins, held west never moves
        btn_north = 1'b1;
        btn_west  = 1'b1;
        tick();
        chk("prio_north", dirs(), 8'b1000);
        chk("prio_count", move_count, 8'd2);
        btn_north = 1'b0;
        tick();
        chk("prio_drop", dirs(), 8'd0);
        tick(); tick(); tick();
        chk("west_held_dirs", dirs(), 8'd0);
        chk("west_held_count", move_count, 8'd2);
        btn_west = 1'b0;

        // third move ends with win and die both high: win wins even at the move budget
        btn_south = 1'b1;
        tick();
        chk("south_pulse", dirs(), 8'b0100);
        chk("south_count", move_count, 8'd3);
        btn_south = 1'b0;
        win = 1'b1;
        die = 1'b1;
        tick(); tick();
        chk("settle_not_over", {7'b0, game_over}, 8'd0);
        tick();
        chk("win_over", {7'b0, game_over}, 8'd1);
        chk("win_result", {6'b0, result}, 8'd1);
        win = 1'b0;
        die = 1'b0;
        tick();
        chk("done_hold", {7'b0, game_over}, 8'd1);
        chk("done_dirs", dirs(), 8'd0);

        // press in DONE restarts; east held through RESTART stays quiet
        btn_east = 1'b1;
        tick();
        chk("rs_game_reset1", {7'b0, game_reset}, 8'd1);
        chk("rs_count", move_count, 8'd0);
        chk("rs_result", {6'b0, result}, 8'd0);
        tick();
        chk("rs_game_reset2", {7'b0, game_reset}, 8'd1);
        tick();
        chk("rs_exit", {7'b0, game_reset}, 8'd0);
        tick();
        chk("rs_hold_dirs", dirs(), 8'd0);
        chk("rs_hold_count", move_count, 8'd0);
        btn_east = 1'b0;

        // three moves with no win/die hit the move budget
        for (int i = 0; i < 3; i++) begin
            btn_south = 1'b1;
            tick();
            chk("to_pulse", dirs(), 8'b0100);
            chk("to_count", move_count, 8'(i + 1));
            btn_south = 1'b0;
            tick(); tick(); tick();
            chk("to_over", {7'b0, game_over}, (i == 2) ? 8'd1 : 8'd0);
        end
        chk("to_result", {6'b0, result}, 8'd3);

        // restart, then reset asserted in the middle of a move
        btn_east = 1'b1;
        tick(); tick(); tick();
        chk("rs2_idle", {7'b0, game_reset}, 8'd0);
        btn_east  = 1'b0;
        btn_north = 1'b1;
        tick();
        chk("mv_north", dirs(), 8'b1000);
        reset = 1'b0;
        #1;
        chk("async_dirs", dirs(), 8'd0);
        chk("async_game_reset", {7'b0, game_reset}, 8'd1);
        chk("async_count", move_count, 8'd0);
        btn_north = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_c1", {7'b0, game_reset}, 8'd1);
        tick();
        chk("post_rst_idle", {7'b0, game_reset}, 8'd0);
        chk("post_rst_dirs", dirs(), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adventure_controller.md
ADVENTURE_CONTROLLER -- requirements
Module: adventure_controller

Interface
REQ-001 The block SHALL have parameter MOVE_GAP, 2, number of settle cycles after each move pulse before another press is accepted (1..15).
REQ-002 The block SHALL have parameter MAX_MOVES, 200, move budget; reaching it without a win ends the game as timeout (1..255).
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports btn_north, btn_south, btn_west, btn_east  input  1 each  synchronised button levels.
REQ-006 The block SHALL have ports win, die  input  1 each  game status from the room/sword game.
REQ-007 The block SHALL have ports north, south, west, east  output  1 each  one-cycle move pulses to the game.
REQ-008 The block SHALL have port game_reset  output  1  active-high reset driven to the game.
REQ-009 The block SHALL have port move_count  output  8  accepted moves since last game start.
REQ-010 The block SHALL have ports game_over  output  1, and result  output  2 (NONE=0, WIN=1, DIE=2, TIMEOUT=3).

Function
REQ-011 States SHALL be RESTART, IDLE, MOVE, SETTLE, DONE.
REQ-012 A press SHALL be a rising edge of a btn_* level (previous-cycle low, current high); held buttons SHALL not repeat.
REQ-013 In IDLE, if one or more presses occur in the same cycle, priority north > south > west > east SHALL select one; others SHALL be discarded, not queued.
REQ-014 Selected press SHALL cause IDLE->MOVE; in MOVE exactly one direction output is high for exactly one cycle, move_count increments by 1 (saturate 255).
REQ-015 MOVE->SETTLE unconditionally; SETTLE SHALL last MOVE_GAP cycles; presses during MOVE/SETTLE SHALL be ignored.
REQ-016 In IDLE or at SETTLE end, win=1 SHALL go to DONE with result=WIN; else die=1 -> DIE; else move_count==MAX_MOVES -> TIMEOUT; else SETTLE->IDLE. Win takes precedence over die.
REQ-017 In DONE, game_over=1, result held, direction outputs 0; a press of any button SHALL go to RESTART.
REQ-018 RESTART SHALL assert game_reset for exactly 2 cycles, clear move_count and result to 0, then enter IDLE; presses during RESTART ignored.
REQ-019 Direction outputs SHALL be 0 in every state except MOVE; game_reset SHALL be 1 only in RESTART.
REQ-020 Edge-detect history SHALL update every cycle in every state, so a button held through RESTART does not produce a press in IDLE.

Reset
REQ-021 reset low SHALL asynchronously force state RESTART with its 2-cycle counter at start, move_count=0, result=NONE, game_over=0, direction outputs 0, game_reset=1, edge history=0.
REQ-022 Reset asserted mid-MOVE SHALL immediately drop the pulse; after release the 2-cycle RESTART sequence SHALL run in full.

Structure
REQ-023 State enum adv_ctrl_state_type and result enum adv_result_type SHALL live in shared package adv_ctrl_pkg.
REQ-024 Per-button rising-edge detection SHALL be one sub-module, btn_edge, instantiated four times.
REQ-025 The controller SHALL instantiate no game logic; the game connects externally to north/south/west/east/game_reset/win/die.

Verification
REQ-026 Reset release, no buttons -> game_reset high 2 cycles, then IDLE, move_count=0, result=0.
REQ-027 btn_east pulse in IDLE -> east high exactly 1 cycle next cycle, move_count=1, next press accepted no earlier than 1+MOVE_GAP cycles later.
REQ-028 btn_north and btn_west rise same cycle -> only north pulses, move_count=1; btn_west held high produces no later move.
REQ-029 win=1 at SETTLE end -> game_over=1, result=1, further presses inactive until one press -> game_reset 2 cycles, move_count=0.
REQ-030 MAX_MOVES=3, three moves with win=die=0 -> after third SETTLE result=3, game_over=1; win and die both 1 -> result=1.
REQ-031 reset pulled low during MOVE -> all direction outputs 0 same cycle, game_reset=1 asynchronously.
